// File: rtl/ppm_encoder_if.sv
// PPM encoder bus: channel values and enable in, PPM line and frame status out.
// Ports: ch_values (NUM_CH*8, channel i at [8i+7:8i]), enable, ppm, frame_start, busy.
// master = the side driving values/enable; slave = the encoder.
interface ppm_encoder_if #(
  parameter int NUM_CH = 8
);
  logic [NUM_CH*8-1:0] ch_values;
  logic                enable;
  logic                ppm;
  logic                frame_start;
  logic                busy;

  modport master (
    output ch_values, enable,
    input  ppm, frame_start, busy
  );

  modport slave (
    input  ch_values, enable,
    output ppm, frame_start, busy
  );
endinterface

// File: rtl/ppm_encoder.sv
// Multi-channel RC PPM transmitter: serializes NUM_CH 8-bit values onto one PPM line
// (255 ticks = 1 ms). Latency: first separator tick on ppm one edge after enable is
// sampled in IDLE, together with frame_start. No backpressure; frames free-run while enable=1.
// Ports: clk_255kHz (tick clock), reset (async, active low), bus (ppm_encoder_if.slave):
//   ch_values/enable in; ppm (registered, INVERT applied after the flop), frame_start, busy out.
module ppm_encoder #(
  parameter int NUM_CH      = 8,
  parameter int SEP_TICKS   = 77,
  parameter int FRAME_TICKS = 5738,
  parameter int MIN_SYNC    = 1020,
  parameter int INVERT      = 0
) (
  input  logic          clk_255kHz,
  input  logic          reset,
  ppm_encoder_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, SLOT, FSEP, GAP} state_t;

  localparam logic [8:0]  SEP_LEN    = 9'(SEP_TICKS);
  localparam logic [8:0]  SEP_LAST   = 9'(SEP_TICKS - 1);
  localparam logic [12:0] FRAME_LAST = 13'(FRAME_TICKS - 1);
  localparam logic [12:0] GAP_LAST   = 13'(MIN_SYNC - 1);
  localparam logic [12:0] CNT_MAX    = 13'h1FFF;
  localparam logic [2:0]  CH_LAST    = 3'(NUM_CH - 1);

  state_t      state_q, state_d;
  logic [2:0]  ch_q, ch_d;
  logic [8:0]  slot_q, slot_d;
  logic [12:0] frame_q, frame_d;
  logic [12:0] gap_q, gap_d;
  logic        ppm_q, ppm_d;
  logic        fs_q, fs_d;
  logic        busy_q, busy_d;
  logic        load;
  logic [7:0]  val_q [8];
  logic [63:0] ch_pad;
  logic [8:0]  slot_last;
  logic [12:0] frame_inc, gap_inc;

  // Values are held in a fixed 8-entry array; entries above NUM_CH-1 are never selected.
  assign ch_pad    = 64'(bus.ch_values);
  assign slot_last = 9'd254 + {1'b0, val_q[ch_q]};
  assign frame_inc = (frame_q == CNT_MAX) ? frame_q : frame_q + 13'd1;
  assign gap_inc   = (gap_q == CNT_MAX) ? gap_q : gap_q + 13'd1;

  always_ff @(posedge clk_255kHz or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      ch_q    <= '0;
      slot_q  <= '0;
      frame_q <= '0;
      gap_q   <= '0;
      ppm_q   <= 1'b0;
      fs_q    <= 1'b0;
      busy_q  <= 1'b0;
      for (int i = 0; i < 8; i++) val_q[i] <= '0;
    end else begin
      state_q <= state_d;
      ch_q    <= ch_d;
      slot_q  <= slot_d;
      frame_q <= frame_d;
      gap_q   <= gap_d;
      ppm_q   <= ppm_d;
      fs_q    <= fs_d;
      busy_q  <= busy_d;
      if (load) begin
        for (int i = 0; i < 8; i++) val_q[i] <= ch_pad[8*i +: 8];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    ch_d    = ch_q;
    slot_d  = slot_q;
    frame_d = frame_inc;
    gap_d   = gap_q;
    load    = 1'b0;

    case (state_q)
      IDLE: begin
        frame_d = '0;
        if (bus.enable) load = 1'b1;
      end
      SLOT: begin
        if (slot_q == slot_last) begin
          slot_d = '0;
          if (ch_q == CH_LAST) state_d = FSEP;
          else                 ch_d    = ch_q + 3'd1;
        end else begin
          slot_d = slot_q + 9'd1;
        end
      end
      FSEP: begin
        if (slot_q == SEP_LAST) begin
          slot_d  = '0;
          gap_d   = '0;
          state_d = GAP;
        end else begin
          slot_d = slot_q + 9'd1;
        end
      end
      GAP: begin
        gap_d = gap_inc;
        // Frame ends only when both the nominal length and the minimum sync gap are met.
        if ((gap_q >= GAP_LAST) && (frame_q >= FRAME_LAST)) begin
          if (bus.enable) begin
            load = 1'b1;
          end else begin
            state_d = IDLE;
            frame_d = '0;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    if (load) begin
      state_d = SLOT;
      ch_d    = '0;
      slot_d  = '0;
      frame_d = '0;
      gap_d   = '0;
    end

    // Outputs are registered from the next state so ppm lines up with frame_start.
    ppm_d  = ((state_d == SLOT) && (slot_d < SEP_LEN)) || (state_d == FSEP);
    fs_d   = load;
    busy_d = (state_d != IDLE);
  end

  assign bus.ppm         = ppm_q ^ (INVERT != 0);
  assign bus.frame_start = fs_q;
  assign bus.busy        = busy_q;

endmodule

// File: tb/tb_ppm_encoder.sv
// Self-checking bench for ppm_encoder: a default 8-channel instance and a
// 4-channel FRAME_TICKS=2000 instance, checked against a frame-level model.
module tb_ppm_encoder;
  localparam int SEP   = 77;
  localparam int MSYNC = 1020;
  localparam int BIG   = 100000;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  ppm_encoder_if #(.NUM_CH(8)) ifa ();
  ppm_encoder_if #(.NUM_CH(4)) ifb ();

  ppm_encoder #(.NUM_CH(8)) dut_a (
    .clk_255kHz (clk),
    .reset      (rst_n),
    .bus        (ifa.slave)
  );

  ppm_encoder #(.NUM_CH(4), .FRAME_TICKS(2000)) dut_b (
    .clk_255kHz (clk),
    .reset      (rst_n),
    .bus        (ifb.slave)
  );

  int n_checks = 0;
  int n_pass   = 0;
  int hist [8192];

  typedef struct {
    bit          sel;
    logic [63:0] vals;
    int          exp_len;
  } vec_t;
  vec_t vecs [6];

  // ---------------- reference model (frame-level arithmetic) ----------------
  function automatic int slot_start(input logic [63:0] v, input int nch, input int k);
    int s = 0;
    for (int i = 0; i < k && i < nch; i++) s += 255 + int'(v[8*i +: 8]);
    return s;
  endfunction

  function automatic int frame_len_m(input logic [63:0] v, input int nch, input int ft);
    int s = slot_start(v, nch, nch) + SEP + MSYNC;
    return (s > ft) ? s : ft;
  endfunction

  function automatic int ppm_m(input logic [63:0] v, input int nch, input int t);
    int p = t;
    for (int i = 0; i < nch; i++) begin
      int l = 255 + int'(v[8*i +: 8]);
      if (p < l) return (p < SEP) ? 1 : 0;
      p -= l;
    end
    return (p < SEP) ? 1 : 0;
  endfunction

  // ---------------- helpers ----------------
  task automatic chk_eq(input int act, input int exp, input string name);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  task automatic set_en(input bit sel, input logic v);
    if (sel) ifb.enable = v; else ifa.enable = v;
  endtask

  task automatic set_vals(input bit sel, input logic [63:0] v);
    if (sel) ifb.ch_values = v[31:0]; else ifa.ch_values = v;
  endtask

  function automatic logic [63:0] get_vals(input bit sel);
    return sel ? {32'h0, ifb.ch_values} : ifa.ch_values;
  endfunction

  function automatic logic o_ppm(input bit sel);  return sel ? ifb.ppm : ifa.ppm; endfunction
  function automatic logic o_fs(input bit sel);   return sel ? ifb.frame_start : ifa.frame_start; endfunction
  function automatic logic o_busy(input bit sel); return sel ? ifb.busy : ifa.busy; endfunction

  task automatic wait_fs(input bit sel, input int budget, input string name);
    int found = 0;
    for (int i = 0; i < budget; i++) begin
      if (o_fs(sel) === 1'b1) begin
        found = 1;
        break;
      end
      @(negedge clk);
    end
    chk_eq(found, 1, name);
  endtask

  task automatic idle_check(input bit sel, input int n, input string name);
    int bad = -1;
    for (int t = 0; t < n; t++) begin
      if (bad < 0 && (o_ppm(sel) !== 1'b0 || o_fs(sel) !== 1'b0 || o_busy(sel) !== 1'b0)) bad = t;
      @(negedge clk);
    end
    chk_eq(bad, -1, {name, "_idle_bad_tick"});
  endtask

  // Called on the negedge of tick 0 of a frame; checks ticks 0..min(limit,exp_len)-1.
  task automatic run_frame(input bit sel, input logic [63:0] v, input int nch, input int exp_len,
                           input bit keep_en, input int drop_tick, input int chg_tick,
                           input bit rnd_chg, input int limit, input string name);
    int bad_ppm = -1, bad_busy = -1, bad_fs = -1;
    int n = (limit < exp_len) ? limit : exp_len;
    for (int t = 0; t < n; t++) begin
      logic p;
      p = o_ppm(sel);
      hist[t] = int'(p);
      if (bad_ppm < 0 && p !== ppm_m(v, nch, t)) bad_ppm = t;
      if (bad_busy < 0 && o_busy(sel) !== 1'b1) bad_busy = t;
      if (bad_fs < 0 && o_fs(sel) !== (t == 0)) bad_fs = t;
      if (t == drop_tick) set_en(sel, 1'b0);
      if (t == chg_tick) set_vals(sel, {get_vals(sel)[63:8], 8'h40});
      if (rnd_chg && $urandom_range(0, 63) == 0) set_vals(sel, {$urandom, $urandom});
      @(negedge clk);
    end
    chk_eq(bad_ppm, -1, {name, "_ppm_bad_tick"});
    chk_eq(bad_busy, -1, {name, "_busy_bad_tick"});
    chk_eq(bad_fs, -1, {name, "_fs_bad_tick"});
    if (n == exp_len) begin
      if (keep_en) chk_eq(int'(o_fs(sel)), 1, {name, "_next_frame_start"});
      else chk_eq(int'({o_ppm(sel), o_fs(sel), o_busy(sel)}), 0, {name, "_end_ppm_fs_busy"});
    end
  endtask

  // ---------------- test sequence ----------------
  initial begin
    logic [63:0] v;
    int nch, drop, exp;

    rst_n = 1'b0;
    ifa.enable = 1'b0;  ifb.enable = 1'b0;
    ifa.ch_values = '0; ifb.ch_values = '0;

    vecs[0] = '{1'b0, 64'h0,                    5738};
    vecs[1] = '{1'b0, 64'hFFFFFFFF_FFFFFFFF,    5738};
    vecs[2] = '{1'b0, 64'h80808080_FF808000,    5738};
    vecs[3] = '{1'b1, 64'h00000000_FFFFFFFF,    3137};
    vecs[4] = '{1'b1, 64'h0,                    2117};
    vecs[5] = '{1'b1, 64'h00000000_80808080,    2629};

    repeat (3) @(negedge clk);
    chk_eq(int'(ifa.ppm), 0, "rst_ppm_a");
    chk_eq(int'(ifa.busy), 0, "rst_busy_a");
    chk_eq(int'(ifa.frame_start), 0, "rst_fs_a");
    chk_eq(int'(ifb.ppm), 0, "rst_ppm_b");
    chk_eq(int'(ifb.busy), 0, "rst_busy_b");
    chk_eq(int'(ifb.frame_start), 0, "rst_fs_b");
    rst_n = 1'b1;
    @(negedge clk);
    idle_check(1'b0, 5, "post_rst_a");

    // Table: one frame per pattern, enable dropped mid-frame (slot 5 or last slot).
    for (int i = 0; i < 6; i++) begin
      nch = vecs[i].sel ? 4 : 8;
      set_vals(vecs[i].sel, vecs[i].vals);
      set_en(vecs[i].sel, 1'b1);
      @(negedge clk);
      wait_fs(vecs[i].sel, 4, $sformatf("vec%0d_start", i));
      drop = slot_start(vecs[i].vals, nch, (nch > 5) ? 5 : nch - 1) + 10;
      run_frame(vecs[i].sel, vecs[i].vals, nch, vecs[i].exp_len, 1'b0, drop, -1, 1'b0, BIG,
                $sformatf("vec%0d", i));
      idle_check(vecs[i].sel, 10, $sformatf("vec%0d", i));
    end

    // Mid-frame value change: current frame unaffected, next frame picks it up.
    set_vals(1'b0, 64'h80808080_FF808000);
    set_en(1'b0, 1'b1);
    @(negedge clk);
    wait_fs(1'b0, 4, "mix_start");
    v = get_vals(1'b0);
    run_frame(1'b0, v, 8, 5738, 1'b1, -1, 700, 1'b0, BIG, "mix_f1");
    chk_eq(hist[254], 0, "mix_f1_slot0_last_low");
    chk_eq(hist[255], 1, "mix_f1_slot1_sep");
    v = get_vals(1'b0);
    run_frame(1'b0, v, 8, 5738, 1'b0, 2000, -1, 1'b0, BIG, "mix_f2");
    chk_eq(hist[318], 0, "mix_f2_slot0_last_low");
    chk_eq(hist[319], 1, "mix_f2_slot1_sep");
    idle_check(1'b0, 10, "mix_f2");

    // Random back-to-back frames with values churning mid-frame.
    set_vals(1'b0, {$urandom, $urandom});
    set_en(1'b0, 1'b1);
    @(negedge clk);
    wait_fs(1'b0, 4, "rnd_a_start");
    for (int f = 0; f < 2; f++) begin
      v = get_vals(1'b0);
      exp = frame_len_m(v, 8, 5738);
      run_frame(1'b0, v, 8, exp, f < 1, (f < 1) ? -1 : int'($urandom_range(0, exp - 1)), -1,
                1'b1, BIG, $sformatf("rnd_a%0d", f));
    end
    idle_check(1'b0, 5, "rnd_a");

    set_vals(1'b1, {32'h0, $urandom});
    set_en(1'b1, 1'b1);
    @(negedge clk);
    wait_fs(1'b1, 4, "rnd_b_start");
    for (int f = 0; f < 3; f++) begin
      v = get_vals(1'b1);
      exp = frame_len_m(v, 4, 2000);
      run_frame(1'b1, v, 4, exp, f < 2, (f < 2) ? -1 : int'($urandom_range(0, exp - 1)), -1,
                1'b1, BIG, $sformatf("rnd_b%0d", f));
    end
    idle_check(1'b1, 5, "rnd_b");

    // Asynchronous reset while the first separator is high, then a clean restart.
    set_vals(1'b0, 64'h01010101_01010101);
    set_en(1'b0, 1'b1);
    @(negedge clk);
    wait_fs(1'b0, 4, "rstmid_start");
    v = get_vals(1'b0);
    run_frame(1'b0, v, 8, frame_len_m(v, 8, 5738), 1'b1, -1, -1, 1'b0, 30, "rstmid_pre");
    chk_eq(int'(ifa.ppm), 1, "rstmid_ppm_before");
    #2 rst_n = 1'b0;
    #1;
    chk_eq(int'(ifa.ppm), 0, "rstmid_async_ppm");
    chk_eq(int'(ifa.busy), 0, "rstmid_async_busy");
    chk_eq(int'(ifa.frame_start), 0, "rstmid_async_fs");
    @(negedge clk);
    rst_n = 1'b1;
    wait_fs(1'b0, 4, "rstmid_restart");
    run_frame(1'b0, v, 8, frame_len_m(v, 8, 5738), 1'b1, -1, -1, 1'b0, 300, "rstmid_post");
    chk_eq(hist[76], 1, "rstmid_sep_last_high");
    chk_eq(hist[77], 0, "rstmid_sep_end_low");
    set_en(1'b0, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/ppm_encoder.md
Name: ppm_encoder

Overview:
- Multi-channel RC PPM (pulse-position modulation) transmitter: serializes NUM_CH 8-bit channel values onto one PPM line, frame by frame.
- It is the transmit-side counterpart of the RC receiver peripheral. Its output feeds an RC trainer/radio-module port or a downstream PPM decoder.
- It uses the same timebase as the PWM blocks: 255 ticks = 1 ms. A channel value of 0 gives a 1 ms slot; 255 gives a 2 ms slot.

Parameters:
- NUM_CH, 8: channels per frame; 1..8.
- SEP_TICKS, 77: separator pulse length in ticks (~0.3 ms); 1..254.
- FRAME_TICKS, 5738: nominal frame length in ticks (~22.5 ms); must be ≤ 8191.
- MIN_SYNC, 1020: minimum low sync gap after the final separator (~4 ms).
- INVERT, 0: 1 inverts the ppm output.

Ports:
- clk_255kHz  in  1  tick clock; all logic is on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- ch_values  in  NUM_CH*8  channel values; channel i is bits [8i+7:8i].
- enable  in  1  1 = transmit frames continuously.
- ppm  out  1  PPM stream; registered.
- frame_start  out  1  one-cycle pulse on the first tick of each frame.
- busy  out  1  high while a frame is in progress.

Behaviour:
- Reset (reset=0, asynchronous):
  - State is IDLE; all counters are 0.
  - Outputs: ppm=INVERT, frame_start=0, busy=0. Latched values are cleared to 0.
  - Asserting reset mid-frame aborts the frame immediately; no partial pulse stretching.
- After reset release: the first edge with enable=1 in IDLE starts a frame.
- States: IDLE, SLOT, FSEP, GAP.
- IDLE:
  - ppm = idle level (low ^ INVERT).
  - If enable=1 at a rising edge:
    - Latch all of ch_values atomically into an internal array.
    - Go to SLOT with channel index 0.
    - frame_start=1 and busy=1 in that same registered cycle.
- SLOT (channel i, width w_i):
  - Lasts exactly 255+w_i ticks (255..510).
  - ppm is high for the first SEP_TICKS ticks, then low.
  - Slot counter: 9 bits, runs 0..254+w_i. The addition is 9-bit and never wraps.
  - At the last tick: if i < NUM_CH-1, start slot i+1 on the next tick; otherwise go to FSEP.
- FSEP: ppm high for SEP_TICKS ticks. This separator terminates the last channel.
- GAP:
  - ppm low.
  - Exit when the frame counter reaches FRAME_TICKS-1 and the gap has lasted ≥ MIN_SYNC ticks.
  - Frame length = max(FRAME_TICKS, Σ(255+w_i)+SEP_TICKS+MIN_SYNC). The stretch case occurs only with parameter overrides.
  - Frame counter: 13 bits, counts every tick from frame start, saturates at 8191.
- End of GAP:
  - enable=1: the next frame starts on the next tick (back-to-back, no IDLE cycle); values are re-latched and frame_start pulses.
  - enable=0: go to IDLE; busy=0 on the next tick.
- Changes to ch_values mid-frame have no effect until the next frame latch.
- enable deasserted mid-frame: the current frame completes in full, including GAP.
- The INVERT XOR is applied after the output register. There is no combinational path from inputs to ppm.
- Latency: the first separator edge appears on ppm in the same registered cycle as frame_start, i.e. one edge after enable is sampled in IDLE.

Test Plan:
- Default params, all values 0, enable held high:
  - Each of 8 slots is 255 ticks (77 high, 178 low); FSEP is 77 high.
  - Frame is exactly 5738 ticks; frame_start pulses every 5738 cycles.
- All values 255: slots are 510 ticks; gap = 5738 − 4080 − 77 = 1581 ticks; frame is still 5738.
- ch0=0x00, ch3=0xFF, others 0x80; then ch0 changes to 0x40 during slot 2:
  - Current frame's slot 0 remains 255 ticks.
  - Next frame's slot 0 is 319 ticks.
- Override FRAME_TICKS=2000, NUM_CH=4, values 255:
  - Gap is stretched to 1020 ticks.
  - Frame is 4·510+77+1020 = 3137 ticks.
- enable dropped during slot 5:
  - Frame completes, ending exactly at 5738 ticks.
  - busy falls the tick after GAP ends; ppm stays low; no further frame_start.
- reset pulsed low mid-SLOT while ppm is high:
  - Asynchronously, ppm=0, busy=0, frame_start=0.
  - After release with enable=1, a fresh frame starts with slot 0 and a full 77-tick separator.
